// File: rtl/avg_pkg.sv
// rtl/avg_pkg.sv - shared AVG opcodes, fetch state encoding and stack depth default
package avg_pkg;

  localparam logic [2:0] OP_VCTR = 3'b000;
  localparam logic [2:0] OP_HALT = 3'b001;
  localparam logic [2:0] OP_SVEC = 3'b010;
  localparam logic [2:0] OP_STAT = 3'b011;
  localparam logic [2:0] OP_CNTR = 3'b100;
  localparam logic [2:0] OP_JSR  = 3'b101;
  localparam logic [2:0] OP_RTS  = 3'b110;
  localparam logic [2:0] OP_JMP  = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT
  } fetch_state_t;

  localparam int DEF_STACK_DEPTH = 4;

endpackage

// File: rtl/avg_ret_stack.sv
// rtl/avg_ret_stack.sv - circular JSR return stack with wrap and overflow/underflow flags
module avg_ret_stack
  import avg_pkg::*;
#(
  parameter int DEPTH  = DEF_STACK_DEPTH,
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic              pop,
  input  logic [ADDR_W-1:0] push_data,
  output logic [ADDR_W-1:0] pop_data,
  output logic              overflow,
  output logic              underflow
);

  localparam int SP_W = $clog2(DEPTH);
  localparam logic [SP_W:0] FULL = (SP_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] entries [DEPTH];
  logic [SP_W-1:0]   sp;
  logic [SP_W-1:0]   sp_dec;
  logic [SP_W:0]     cnt;

  // cnt tracks occupancy so a full wrap is told apart from an empty stack
  assign sp_dec    = sp - SP_W'(1);
  assign pop_data  = entries[sp_dec];
  assign overflow  = push && !clr && (cnt == FULL);
  assign underflow = pop && !clr && (cnt == '0);

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      entries[sp] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push) begin
      sp <= sp + SP_W'(1);
      if (cnt != FULL) begin
        cnt <= cnt + (SP_W + 1)'(1);
      end
    end else if (pop) begin
      sp <= sp_dec;
      if (cnt != '0) begin
        cnt <= cnt - (SP_W + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/avg_fetch.sv
// rtl/avg_fetch.sv - AVG instruction fetch: byte reads, word assembly, PC and return stack
// Define AVG_SHORT_FETCH_EN to end non-VCTR fetches after two bytes.
module avg_fetch
  import avg_pkg::*;
#(
  parameter int STACK_DEPTH = DEF_STACK_DEPTH,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              vg_reset,
  output logic              halted,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic [31:0]       inst,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic [2:0]        dec_pc_offset,
  input  logic              dec_halt,
  input  logic              dec_jmp,
  input  logic              dec_jsr,
  input  logic              dec_ret,
  input  logic [15:0]       dec_jump_addr,
  output logic              stack_err
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [2:0]        rd_cnt;
  logic [1:0]        cap_cnt;
  logic              rd_q;

  logic              accept;
  logic              do_push;
  logic              do_pop;
  logic              stk_clr;
  logic              stk_over;
  logic              stk_under;
  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] pop_addr;
  logic [ADDR_W-1:0] next_pc;

  assign accept  = (state == PRESENT) && inst_valid && inst_ready;
  assign seq_pc  = pc + ADDR_W'(dec_pc_offset);
  assign do_push = accept && !dec_halt && dec_jsr;
  assign do_pop  = accept && !dec_halt && !dec_jsr && !dec_jmp && dec_ret;
  assign stk_clr = vg_reset || ((state == IDLE) && go);

  always_comb begin
    next_pc = seq_pc;
    if (dec_jsr || dec_jmp) begin
      next_pc = ADDR_W'(dec_jump_addr);
    end else if (dec_ret) begin
      next_pc = pop_addr;
    end
  end

  avg_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ret_stack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (stk_clr),
    .push     (do_push),
    .pop      (do_pop),
    .push_data(seq_pc),
    .pop_data (pop_addr),
    .overflow (stk_over),
    .underflow(stk_under)
  );

  // rd_q marks the cycle where mem_data answers the previous cycle's mem_rd
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      halted     <= 1'b1;
      mem_rd     <= 1'b0;
      mem_addr   <= '0;
      inst       <= '0;
      inst_valid <= 1'b0;
      stack_err  <= 1'b0;
      rd_cnt     <= '0;
      cap_cnt    <= '0;
      rd_q       <= 1'b0;
    end else if (vg_reset) begin
      state      <= IDLE;
      pc         <= '0;
      halted     <= 1'b1;
      mem_rd     <= 1'b0;
      inst_valid <= 1'b0;
      rd_q       <= 1'b0;
    end else begin
      rd_q <= mem_rd;
      unique case (state)
        IDLE: begin
          if (go) begin
            state     <= FETCH;
            halted    <= 1'b0;
            pc        <= '0;
            stack_err <= 1'b0;
            mem_rd    <= 1'b1;
            mem_addr  <= '0;
            rd_cnt    <= 3'd1;
            cap_cnt   <= 2'd0;
          end
        end
        FETCH: begin
          if (rd_cnt != 3'd4) begin
            mem_rd   <= 1'b1;
            mem_addr <= mem_addr + ADDR_W'(1);
            rd_cnt   <= rd_cnt + 3'd1;
          end else begin
            mem_rd <= 1'b0;
          end
          if (rd_q) begin
            unique case (cap_cnt)
              2'd0: inst[31:24] <= mem_data;
              2'd1: inst[23:16] <= mem_data;
              2'd2: inst[15:8]  <= mem_data;
              2'd3: inst[7:0]   <= mem_data;
            endcase
            cap_cnt <= cap_cnt + 2'd1;
            if (cap_cnt == 2'd3) begin
              state      <= PRESENT;
              inst_valid <= 1'b1;
            end
`ifdef AVG_SHORT_FETCH_EN
            if ((cap_cnt == 2'd1) && (mem_data[7:5] != OP_VCTR)) begin
              state       <= PRESENT;
              inst_valid  <= 1'b1;
              mem_rd      <= 1'b0;
              inst[15:0]  <= 16'h0000;
            end
`endif
          end
        end
        PRESENT: begin
          if (accept) begin
            inst_valid <= 1'b0;
            if (dec_halt) begin
              state  <= IDLE;
              halted <= 1'b1;
            end else begin
              state    <= FETCH;
              pc       <= next_pc;
              mem_rd   <= 1'b1;
              mem_addr <= next_pc;
              rd_cnt   <= 3'd1;
              cap_cnt  <= 2'd0;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (stk_over || stk_under) begin
        stack_err <= 1'b1;
      end
    end
  end

endmodule
